// File: rtl/cp0_int_ctrl.sv
// cp0_int_ctrl: interrupt sequencer between device IRQ lines, CP0 and the
// multi-cycle CPU FSM. Device requests are synchronised and latched into a
// pending vector (CP0 HWInt). At a safe instruction boundary, a CP0 IntReq
// causes an entry sequence (EXL set, EPC capture, PC redirect). ERET causes an
// exit sequence (EXL clear, device acknowledge). Only one interrupt is in
// service at a time.
//
// Strobe semantics: exl_set, cp0_wr, take_int, exl_clr and irq_ack are
// single-cycle Moore pulses. They are decoded only from the state register,
// so each pulse is high for exactly the one cycle the FSM spends in ENTER or
// EXIT. No consumer handshake is needed: CP0 and the CPU FSM must act on the
// pulse in the cycle it is high.
module cp0_int_ctrl #(
    parameter int          NUM_IRQ      = 6,
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] irq_edge,
    input  logic               instr_boundary,
    input  logic [31:0]        cur_pc,
    input  logic               eret,
    input  logic               int_req,
    output logic [NUM_IRQ-1:0] hw_int,
    output logic               cp0_wr,
    output logic               exl_set,
    output logic               exl_clr,
    output logic [31:0]        epc_pc,
    output logic               take_int,
    output logic [31:0]        vec_pc,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic [2:0]         active_irq,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ENTER   = 2'd1,
        ST_HANDLER = 2'd2,
        ST_EXIT    = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Synchroniser chain. r_sync3 is the previous synchronised value and is
    // used only for rising-edge detection.
    logic [NUM_IRQ-1:0] r_sync1;
    logic [NUM_IRQ-1:0] r_sync2;
    logic [NUM_IRQ-1:0] r_sync3;
    logic [NUM_IRQ-1:0] r_pending;
    logic [31:0]        r_epc;
    logic [2:0]         r_active;

    logic [NUM_IRQ-1:0] w_rise;
    logic [NUM_IRQ-1:0] w_active_onehot;
    logic [NUM_IRQ-1:0] w_clr;
    logic [NUM_IRQ-1:0] w_pending_next;
    logic [2:0]         w_winner;
    logic               w_any_pending;
    logic               w_capture;

    // Two-flop synchroniser plus one delay stage for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
        end else begin
            r_sync1 <= irq_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // One-hot decode of the line in service.
    always_comb begin
        w_active_onehot = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_active_onehot[i] = (r_active == 3'(i));
        end
    end

    // Pending next-state. Edge lines latch a synchronised 0->1 and clear only
    // in EXIT for the serviced line; a new edge in that same cycle wins over
    // the clear so the request is not lost. Level lines simply track the
    // synchronised input.
    always_comb begin
        w_rise = r_sync2 & ~r_sync3;
        w_clr  = (r_state == ST_EXIT) ? w_active_onehot : '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (irq_edge[i]) begin
                w_pending_next[i] = w_rise[i] | (r_pending[i] & ~w_clr[i]);
            end else begin
                w_pending_next[i] = r_sync2[i];
            end
        end
    end

    // Registered pending stage; this is what CP0 sees as HWInt.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_next;
        end
    end

    // Fixed priority: lowest pending index wins.
    always_comb begin
        w_winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_winner = 3'(i);
            end
        end
        w_any_pending = |r_pending;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state and Moore strobe decode.
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        exl_set      = 1'b0;
        cp0_wr       = 1'b0;
        take_int     = 1'b0;
        exl_clr      = 1'b0;
        irq_ack      = '0;
        case (r_state)
            ST_IDLE: begin
                // eret is ignored here: nothing is in service.
                if (int_req && instr_boundary && w_any_pending) begin
                    w_next_state = ST_ENTER;
                    w_capture    = 1'b1;
                end
            end
            ST_ENTER: begin
                exl_set      = 1'b1;
                cp0_wr       = 1'b1;
                take_int     = 1'b1;
                w_next_state = ST_HANDLER;
            end
            ST_HANDLER: begin
                // No nesting: further requests only accumulate in pending.
                if (eret) begin
                    w_next_state = ST_EXIT;
                end
            end
            ST_EXIT: begin
                exl_clr      = 1'b1;
                irq_ack      = w_active_onehot;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Capture resume PC and winning line on the IDLE->ENTER transition;
    // both are held until the next capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_epc    <= '0;
            r_active <= '0;
        end else if (w_capture) begin
            r_epc    <= cur_pc;
            r_active <= w_winner;
        end
    end

    assign hw_int     = r_pending;
    assign epc_pc     = r_epc;
    assign active_irq = r_active;
    assign vec_pc     = HANDLER_ADDR;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Bench for cp0_int_ctrl: a per-cycle vector table run through an expected
// queue, followed by hand-written sequences for the level-mode, set-wins and
// asynchronous-reset corner cases.
module tb_cp0_int_ctrl;

  localparam logic [31:0] HADDR = 32'h0000_4180;
  localparam logic [3:0] S_NONE = 4'b0000;
  localparam logic [3:0] S_ENT  = 4'b1110;  // {exl_set, cp0_wr, take_int, exl_clr}
  localparam logic [3:0] S_EXT  = 4'b0001;

  logic        clk;
  logic        reset;
  logic [5:0]  irq_in;
  logic [5:0]  irq_edge;
  logic        instr_boundary;
  logic [31:0] cur_pc;
  logic        eret;
  logic        int_req;
  logic [5:0]  hw_int;
  logic        cp0_wr;
  logic        exl_set;
  logic        exl_clr;
  logic [31:0] epc_pc;
  logic        take_int;
  logic [31:0] vec_pc;
  logic [5:0]  irq_ack;
  logic [2:0]  active_irq;
  logic [1:0]  dbg_state;

  int n_tests;
  int n_fail;

  typedef struct {
    logic [5:0]  irq;
    logic        ir;
    logic        ib;
    logic [31:0] pc;
    logic        er;
    logic [5:0]  e_hw;
    logic [1:0]  e_st;
    logic [3:0]  e_strb;
    logic [5:0]  e_ack;
    logic [2:0]  e_act;
    logic [31:0] e_epc;
  } vec_t;

  vec_t vecs[$];
  logic [52:0] exp_q[$];

  cp0_int_ctrl #(
    .NUM_IRQ(6),
    .HANDLER_ADDR(HADDR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .irq_in(irq_in),
    .irq_edge(irq_edge),
    .instr_boundary(instr_boundary),
    .cur_pc(cur_pc),
    .eret(eret),
    .int_req(int_req),
    .hw_int(hw_int),
    .cp0_wr(cp0_wr),
    .exl_set(exl_set),
    .exl_clr(exl_clr),
    .epc_pc(epc_pc),
    .take_int(take_int),
    .vec_pc(vec_pc),
    .irq_ack(irq_ack),
    .active_irq(active_irq),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [5:0] irq, input logic ir, input logic ib,
                     input logic [31:0] pc, input logic er,
                     input logic [5:0] ehw, input logic [1:0] est, input logic [3:0] estr,
                     input logic [5:0] eack, input logic [2:0] eact, input logic [31:0] eepc);
    vec_t v;
    v.irq = irq; v.ir = ir; v.ib = ib; v.pc = pc; v.er = er;
    v.e_hw = ehw; v.e_st = est; v.e_strb = estr; v.e_ack = eack;
    v.e_act = eact; v.e_epc = eepc;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [5:0] irq, input logic ir, input logic ib,
                       input logic [31:0] pc, input logic er);
    irq_in = irq; int_req = ir; instr_boundary = ib; cur_pc = pc; eret = er;
  endtask

  initial begin
    logic [52:0] exp_v;
    logic [52:0] act_v;
    n_tests = 0;
    n_fail  = 0;
    irq_edge = 6'b111110;  // line 0 level, others edge
    reset = 1'b0;
    drive(6'h00, 1'b0, 1'b0, 32'h0, 1'b0);

    // reset state
    #1;
    check("rst_hw", 32'(hw_int), 32'h0);
    check("rst_state", 32'(dbg_state), 32'h0);
    check("rst_strobes", {28'h0, exl_set, cp0_wr, take_int, exl_clr}, 32'h0);
    check("rst_ack", 32'(irq_ack), 32'h0);
    check("rst_epc", epc_pc, 32'h0);
    check("rst_vec_pc", vec_pc, HADDR);
    tick();
    tick();
    reset = 1'b1;

    // irq  ir ib pc  er | hw  st strobes ack act epc
    // single edge line 2: latency and entry/exit
    add(6'h04, 0, 0, 32'h0, 0,          6'h00, 0, S_NONE, 6'h00, 0, 32'h0);
    add(6'h04, 0, 0, 32'h0, 0,          6'h00, 0, S_NONE, 6'h00, 0, 32'h0);
    add(6'h04, 0, 0, 32'h0, 0,          6'h04, 0, S_NONE, 6'h00, 0, 32'h0);
    add(6'h04, 1, 1, 32'h0040_0010, 0,  6'h04, 1, S_ENT,  6'h00, 2, 32'h0040_0010);
    add(6'h04, 0, 0, 32'h0, 0,          6'h04, 2, S_NONE, 6'h00, 2, 32'h0040_0010);
    add(6'h00, 0, 0, 32'h0, 1,          6'h04, 3, S_EXT,  6'h04, 2, 32'h0040_0010);
    add(6'h00, 0, 0, 32'h0, 0,          6'h00, 0, S_NONE, 6'h00, 2, 32'h0040_0010);
    add(6'h00, 0, 0, 32'h0, 0,          6'h00, 0, S_NONE, 6'h00, 2, 32'h0040_0010);
    add(6'h00, 0, 0, 32'h0, 0,          6'h00, 0, S_NONE, 6'h00, 2, 32'h0040_0010);
    // lines 1 and 4 together: priority, then line 4
    add(6'h12, 0, 0, 32'h0, 0,          6'h00, 0, S_NONE, 6'h00, 2, 32'h0040_0010);
    add(6'h12, 0, 0, 32'h0, 0,          6'h00, 0, S_NONE, 6'h00, 2, 32'h0040_0010);
    add(6'h12, 0, 0, 32'h0, 0,          6'h12, 0, S_NONE, 6'h00, 2, 32'h0040_0010);
    add(6'h12, 1, 1, 32'h0040_0020, 0,  6'h12, 1, S_ENT,  6'h00, 1, 32'h0040_0020);
    add(6'h00, 0, 0, 32'h0, 0,          6'h12, 2, S_NONE, 6'h00, 1, 32'h0040_0020);
    add(6'h00, 0, 0, 32'h0, 1,          6'h12, 3, S_EXT,  6'h02, 1, 32'h0040_0020);
    add(6'h00, 0, 0, 32'h0, 0,          6'h10, 0, S_NONE, 6'h00, 1, 32'h0040_0020);
    add(6'h00, 1, 1, 32'h0040_0030, 0,  6'h10, 1, S_ENT,  6'h00, 4, 32'h0040_0030);
    add(6'h00, 0, 0, 32'h0, 0,          6'h10, 2, S_NONE, 6'h00, 4, 32'h0040_0030);
    // new edge on line 3 while in HANDLER: latched, no re-entry
    add(6'h08, 1, 1, 32'h0040_0099, 0,  6'h10, 2, S_NONE, 6'h00, 4, 32'h0040_0030);
    add(6'h08, 1, 1, 32'h0040_0099, 0,  6'h10, 2, S_NONE, 6'h00, 4, 32'h0040_0030);
    add(6'h08, 1, 1, 32'h0040_0099, 0,  6'h18, 2, S_NONE, 6'h00, 4, 32'h0040_0030);
    add(6'h08, 0, 0, 32'h0, 1,          6'h18, 3, S_EXT,  6'h10, 4, 32'h0040_0030);
    add(6'h08, 0, 0, 32'h0, 0,          6'h08, 0, S_NONE, 6'h00, 4, 32'h0040_0030);
    add(6'h08, 1, 1, 32'h0040_0040, 0,  6'h08, 1, S_ENT,  6'h00, 3, 32'h0040_0040);
    add(6'h00, 0, 0, 32'h0, 0,          6'h08, 2, S_NONE, 6'h00, 3, 32'h0040_0040);
    add(6'h00, 0, 0, 32'h0, 1,          6'h08, 3, S_EXT,  6'h08, 3, 32'h0040_0040);
    add(6'h00, 0, 0, 32'h0, 0,          6'h00, 0, S_NONE, 6'h00, 3, 32'h0040_0040);
    // int_req with nothing pending, eret in IDLE
    add(6'h00, 1, 1, 32'h0040_0060, 0,  6'h00, 0, S_NONE, 6'h00, 3, 32'h0040_0040);
    add(6'h00, 0, 0, 32'h0, 1,          6'h00, 0, S_NONE, 6'h00, 3, 32'h0040_0040);
    // pending but missing boundary / int_req
    add(6'h04, 0, 0, 32'h0, 0,          6'h00, 0, S_NONE, 6'h00, 3, 32'h0040_0040);
    add(6'h04, 0, 0, 32'h0, 0,          6'h00, 0, S_NONE, 6'h00, 3, 32'h0040_0040);
    add(6'h04, 0, 0, 32'h0, 0,          6'h04, 0, S_NONE, 6'h00, 3, 32'h0040_0040);
    add(6'h04, 1, 0, 32'h0040_0077, 0,  6'h04, 0, S_NONE, 6'h00, 3, 32'h0040_0040);
    add(6'h04, 0, 1, 32'h0040_0077, 0,  6'h04, 0, S_NONE, 6'h00, 3, 32'h0040_0040);
    add(6'h04, 1, 1, 32'h0040_0050, 0,  6'h04, 1, S_ENT,  6'h00, 2, 32'h0040_0050);
    add(6'h00, 0, 0, 32'h0, 0,          6'h04, 2, S_NONE, 6'h00, 2, 32'h0040_0050);
    add(6'h00, 0, 0, 32'h0, 1,          6'h04, 3, S_EXT,  6'h04, 2, 32'h0040_0050);
    add(6'h00, 0, 0, 32'h0, 0,          6'h00, 0, S_NONE, 6'h00, 2, 32'h0040_0050);

    // table run through the expected queue
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].irq, vecs[i].ir, vecs[i].ib, vecs[i].pc, vecs[i].er);
      exp_q.push_back({vecs[i].e_hw, vecs[i].e_st, vecs[i].e_strb, vecs[i].e_ack,
                       vecs[i].e_act, vecs[i].e_epc});
      tick();
      act_v = {hw_int, dbg_state, exl_set, cp0_wr, take_int, exl_clr, irq_ack,
               active_irq, epc_pc};
      exp_v = exp_q.pop_front();
      n_tests++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL vec%0d: got hw=%h st=%0d strb=%b ack=%h act=%0d epc=%h expected hw=%h st=%0d strb=%b ack=%h act=%0d epc=%h",
                 i, act_v[52:47], act_v[46:45], act_v[44:41], act_v[40:35], act_v[34:32], act_v[31:0],
                 exp_v[52:47], exp_v[46:45], exp_v[44:41], exp_v[40:35], exp_v[34:32], exp_v[31:0]);
      end
    end

    // level line 0 held through EXIT
    drive(6'h01, 0, 0, 32'h0, 0);
    tick(); check("t3_lat1", 32'(hw_int), 32'h00);
    tick(); check("t3_lat2", 32'(hw_int), 32'h00);
    tick(); check("t3_lat3", 32'(hw_int), 32'h01);
    drive(6'h01, 1, 1, 32'h0040_0070, 0);
    tick(); check("t3_enter", 32'(dbg_state), 32'd1); check("t3_act", 32'(active_irq), 32'd0);
    drive(6'h01, 0, 0, 32'h0, 0);
    tick(); check("t3_handler", 32'(dbg_state), 32'd2);
    drive(6'h01, 0, 0, 32'h0, 1);
    tick(); check("t3_ack", 32'(irq_ack), 32'h01); check("t3_exl_clr", 32'(exl_clr), 32'd1);
    drive(6'h01, 0, 0, 32'h0, 0);
    tick(); check("t3_hold_a", 32'(hw_int), 32'h01); check("t3_ack_off", 32'(irq_ack), 32'h00);
    tick(); check("t3_hold_b", 32'(hw_int), 32'h01);
    drive(6'h00, 0, 0, 32'h0, 0);
    tick(); check("t3_drop1", 32'(hw_int), 32'h01);
    tick(); check("t3_drop2", 32'(hw_int), 32'h01);
    tick(); check("t3_drop3", 32'(hw_int), 32'h00);

    // new edge on the active line in the EXIT cycle: set wins
    drive(6'h20, 0, 0, 32'h0, 0);
    tick(); tick(); tick(); check("t5_pend", 32'(hw_int), 32'h20);
    drive(6'h20, 1, 1, 32'h0040_0080, 0);
    tick(); check("t5_act", 32'(active_irq), 32'd5);
    drive(6'h00, 0, 0, 32'h0, 0);
    tick(); tick(); tick(); check("t5_handler", 32'(dbg_state), 32'd2);
    drive(6'h20, 0, 0, 32'h0, 0);
    tick();
    drive(6'h20, 0, 0, 32'h0, 1);
    tick(); check("t5_exit", 32'(dbg_state), 32'd3); check("t5_ack", 32'(irq_ack), 32'h20);
    drive(6'h20, 0, 0, 32'h0, 0);
    tick(); check("t5_idle", 32'(dbg_state), 32'd0); check("t5_set_wins", 32'(hw_int), 32'h20);

    // async reset during HANDLER
    drive(6'h20, 1, 1, 32'h0040_0090, 0);
    tick(); check("t6_enter", 32'(dbg_state), 32'd1);
    drive(6'h20, 0, 0, 32'h0, 0);
    tick(); check("t6_handler", 32'(dbg_state), 32'd2); check("t6_epc_pre", epc_pc, 32'h0040_0090);
    #2;
    reset = 1'b0;
    irq_in = 6'h00;
    #1;
    check("t6_hw", 32'(hw_int), 32'h0);
    check("t6_state", 32'(dbg_state), 32'd0);
    check("t6_strobes", {28'h0, exl_set, cp0_wr, take_int, exl_clr}, 32'h0);
    check("t6_ack", 32'(irq_ack), 32'h0);
    check("t6_act", 32'(active_irq), 32'h0);
    check("t6_epc", epc_pc, 32'h0);
    check("t6_vec_pc", vec_pc, HADDR);
    tick();
    reset = 1'b1;
    drive(6'h00, 0, 0, 32'h0, 1);
    tick(); check("t6_eret_clr", 32'(exl_clr), 32'd0); check("t6_eret_state", 32'(dbg_state), 32'd0);
    drive(6'h00, 0, 0, 32'h0, 0);
    tick(); check("t6_idle", 32'(dbg_state), 32'd0);

    // report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
